// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the mux_4to1 select arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [N_REQ-1:0] onehot_sel(input logic [SEL_W-1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit searching from ptr upward, mod 4.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        any    = |req;
        idx    = ptr;
        cand_s = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = ptr + i[SEL_W-1:0];
            if (req[cand_s]) begin
                idx = cand_s;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the mux_4to1 select; optional hold timeout under MUX_ARB_TIMEOUT_EN.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CW       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [SEL_W-1:0] s,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15 || (64'd1 << CW) <= 64'(MAX_HOLD)) begin : g_bad_cfg
        $error("mux_sel_arbiter: MAX_HOLD/CW out of range");
    end

    arb_state_t       state_r, state_nx_s;
    logic [SEL_W-1:0] ptr_r, ptr_nx_s, s_nx_s, pick_idx_s;
    logic [N_REQ-1:0] gnt_nx_s;
    logic             pick_any_s, expire_s, release_s, grant_s, timeout_nx_s;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt_r;

    // Counter holds the number of completed BUSY cycles; the MAX_HOLD-th edge forces release.
    assign expire_s = (cnt_r == CW'(MAX_HOLD - 1));

    // Hold counter restarts on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (grant_s) begin
            cnt_r <= '0;
        end else if (state_r == BUSY) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end
`else
    assign expire_s = 1'b0;
`endif

    assign release_s = (state_r == BUSY) && (done || !req[s] || expire_s);
    assign grant_s   = pick_any_s && ((state_r == IDLE) || release_s);

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (pick_any_s) state_nx_s = BUSY;
                else            state_nx_s = IDLE;
            end
            BUSY: begin
                if (release_s && !pick_any_s) state_nx_s = IDLE;
                else                          state_nx_s = BUSY;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Next values of the registered outputs and the priority pointer.
    always_comb begin
        gnt_nx_s     = gnt;
        s_nx_s       = s;
        ptr_nx_s     = ptr_r;
        timeout_nx_s = (state_r == BUSY) && expire_s && !done && req[s];
        if (grant_s) begin
            gnt_nx_s = onehot_sel(pick_idx_s);
            s_nx_s   = pick_idx_s;
            ptr_nx_s = pick_idx_s + 2'd1;
        end else if (state_nx_s == IDLE) begin
            gnt_nx_s = 4'b0000;
        end else begin
            gnt_nx_s = gnt;
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= 2'd0;
            s       <= 2'd0;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            s       <= s_nx_s;
            gnt     <= gnt_nx_s;
            busy    <= (state_nx_s == BUSY);
            timeout <= timeout_nx_s;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter; timeout vectors depend on MUX_ARB_TIMEOUT_EN.
module tb_mux_sel_arbiter;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] s;
        logic       busy;
        logic       timeout;
        int         id;
    } exp_t;

    exp_t exp_q[$];

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [3:0] req  = 4'b1111;
    logic       done = 1'b0;
    logic [1:0] s;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int n_vec  = 0;
    int n_err  = 0;
    int vec_id = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.MAX_HOLD(3), .CW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .s       (s),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic compare(input string name, input exp_t e);
        n_vec++;
        if (gnt !== e.gnt || s !== e.s || busy !== e.busy || timeout !== e.timeout) begin
            n_err++;
            $display("FAIL %s#%0d: got gnt=%b s=%b busy=%b timeout=%b, want gnt=%b s=%b busy=%b timeout=%b",
                     name, e.id, gnt, s, busy, timeout, e.gnt, e.s, e.busy, e.timeout);
        end
    endtask

    // Monitor: one expected entry per clock edge, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare("vec", exp_q.pop_front());
    end

    task automatic step(input logic [3:0] r, input logic d,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic eb, input logic et);
        exp_t e;
        req  = r;
        done = d;
        e = '{gnt: eg, s: es, busy: eb, timeout: et, id: vec_id};
        vec_id++;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    exp_t rst_exp;

    initial begin
        rst_exp = '{gnt: 4'b0000, s: 2'b00, busy: 1'b0, timeout: 1'b0, id: -1};

        // Reset held with all requests high.
        repeat (2) @(negedge clk);
        compare("reset", rst_exp);
        rst = 1'b0;

        // Idle with no requests.
        repeat (5) step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Single request, then done with request dropped.
        step(4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0);

        // ptr is 3: first grant goes to 3, then done each cycle walks 0,1,2,3,0.
        step(4'b1111, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);

        // Owner withdrawal: 2 granted (ptr -> 3), then req=1001 hands to 3.
        step(4'b0100, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0);
        step(4'b1001, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'b11, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 4'b0000, 2'b11, 1'b0, 1'b0);

`ifdef MUX_ARB_TIMEOUT_EN
        // MAX_HOLD=3: three cycles of grant 0, forced handover to 1 with a timeout pulse.
        step(4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b1);
        step(4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        step(4'b0011, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0);
        // done coincides with expiry: plain release, no timeout pulse.
        step(4'b0011, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
`else
        // Without the timeout path the grant is held indefinitely.
        step(4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        repeat (22) step(4'b0011, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);
`endif

        // Mid-grant asynchronous reset while gnt=1000 (ptr is 1, only req 3).
        step(4'b1000, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 compare("async_rst", rst_exp);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that drives the 2-bit select of the gate-level `mux_4to1` data path. Four requesters compete for the shared mux output. The block grants one requester at a time, presents its index on `s[1:0]`, and holds it until the requester signals completion or a hold timeout expires. It sits directly upstream of `mux_4to1`: `s` connects to the mux `s` port, and `gnt` qualifies which requester owns `y`.

## Interface
- `MAX_HOLD`, 15: maximum BUSY cycles per grant before forced release; legal range 1..15.
- `CW`, 4: width of the hold counter; must satisfy `2**CW > MAX_HOLD`.

Ports:
- `clk` input 1: the block's single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 4: request per requester; level-sensitive.
- `done` input 1: owner finished; sampled only in BUSY.
- `s` output 2: registered select to `mux_4to1`; the index of the current/last grant.
- `gnt` output 4: registered one-hot grant; 0000 when idle.
- `busy` output 1: registered; high while a grant is held.
- `timeout` output 1: registered one-cycle pulse on forced release.

## Operation
- States:
  - IDLE: `gnt`=0, `busy`=0.
  - BUSY: exactly one `gnt` bit set, `busy`=1.
- Priority pointer `ptr[1:0]`:
  - Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - On every grant of index k, `ptr` ← (k+1) mod 4, so the last winner becomes lowest priority.
- IDLE → BUSY: any `req` bit high at an edge.
  - `gnt` ← onehot(k), `s` ← k, hold counter ← 0.
- BUSY, release condition: `done`=1, OR `req[s]`=0 (owner withdrew), OR timeout (see Configuration).
  - If release and any `req` bit high (evaluated with the updated `ptr`): grant the new winner at the same edge, with no idle cycle.
  - The releasing owner may be re-granted if it is the only requester.
  - If release and no `req`: go to IDLE, `gnt` ← 0. `s` keeps its last value.
- BUSY, no release: hold `s`, `gnt`, `ptr`; increment the hold counter.
- Simultaneous `done` and timeout at the same edge: treated as `done`; `timeout` stays 0.
- `s` changes only at grant edges and never while `gnt` is stable.
- Reset values (asynchronous, immediate, including mid-grant): state IDLE, `s`=00, `gnt`=0000, `busy`=0, `timeout`=0, `ptr`=00, counter=0.

## Timing
- Grant latency: 1 cycle.
  - `req` seen high at edge n (in IDLE) gives `gnt`/`s`/`busy` valid after edge n.
- Release latency: 1 cycle.
  - `done` high at edge n gives the new grant or IDLE after edge n.
- Back-to-back handover takes zero bubble cycles; the mux select switches exactly at the handover edge.
- Timeout:
  - A grant issued at edge g is force-released at edge g+MAX_HOLD if no other release occurred.
  - `timeout` is high for the single cycle following that edge.
- `done` in IDLE is ignored.

## Configuration
- Macro: `MUX_ARB_TIMEOUT_EN`.
- Defined:
  - The hold counter, the timeout release path, and the `timeout` pulse are compiled in.
  - `MAX_HOLD` and `CW` take effect.
- Undefined:
  - The counter is removed and `timeout` is tied to 0.
  - A grant is held indefinitely until `done` or owner withdrawal.
  - `MAX_HOLD` and `CW` are unused.

## Structure
- Shared package `mux_arb_pkg` holds:
  - `N_REQ`=4 and `SEL_W`=2.
  - The state enum `arb_state_t {IDLE, BUSY}`.
- Sub-module `rr_pick4`: purely combinational.
  - Inputs: `req[3:0]`, `ptr[1:0]`.
  - Outputs: `any`, `idx[1:0]`.
  - Used by both the IDLE and release paths.
- Top level contains the FSM, `ptr`, the output registers, and the hold counter (counter guarded by the macro).
- The integration bench instantiates this block feeding `mux_4to1` and checks `y == i[s]` whenever `busy`=1.

## Test plan
- Reset/idle:
  - Assert `rst` with `req`=1111 → `s`=00, `gnt`=0000, `busy`=0.
  - Release reset, `req`=0000 for 5 cycles → outputs unchanged.
- Single request: `req`=0100 → one edge later `gnt`=0100, `s`=10, `busy`=1.
  - Pulse `done` → `gnt`=0000 next cycle.
- Round-robin fairness: `req`=1111 held, `done` pulsed each grant → grant order 0,1,2,3,0.
  - `s` sequence 00,01,10,11,00, with no idle cycles between grants.
- Owner withdrawal: granted 2, then `req`=1001 → next edge `gnt`=1000, `s`=11 (`ptr` was 3).
- Timeout (macro defined, `MAX_HOLD`=3): `req`=0011, no `done` → `gnt`=0001 for 3 cycles, then `timeout`=1 for one cycle with `gnt`=0010.
  - With the macro undefined: `gnt`=0001 held for 20+ cycles and `timeout` stays 0.
- Mid-grant reset: assert `rst` asynchronously between edges while `gnt`=1000 → outputs drop to reset values immediately.
  - After release, `req`=1111 → first grant is index 0.
